// File: rtl/mips_main_control.sv
// Multi-cycle MIPS main control FSM: steps each instruction through its states and
// drives datapath enables, mux selects and ALUop. Define MIPS_BNE_EN to add bne support.
module mips_main_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       zero,
   output logic       mem_write,
   output logic       ir_write,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       iord,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic [1:0] alu_op,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       illegal_op
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_BNE_EN
   localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11,
      S_BNEEX   = 4'd12
   } state_t;

   state_t state_reg, state_next;
   logic   pc_write, branch, branch_ne;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= S_FETCH;
      else        state_reg <= state_next;
   end

   assign state = state_reg;

   always_comb begin
      state_next = S_FETCH;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      branch_ne  = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      iord       = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_op     = 2'b00;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      case (state_reg)
         S_FETCH: begin
            alu_src_b  = 2'b01;
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_RTYPEEX;
               OP_BEQ:       state_next = S_BEQEX;
               OP_ADDI:      state_next = S_ADDIEX;
               OP_J:         state_next = S_JEX;
`ifdef MIPS_BNE_EN
               OP_BNE:       state_next = S_BNEEX;
`endif
               default: begin
                  illegal_op = 1'b1;
                  instr_done = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            iord       = 1'b1;
            state_next = S_MEMWB;
         end
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            mem_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_RTYPEEX: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b10;
            state_next = S_RTYPEWB;
         end
         S_RTYPEWB: begin
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_ADDIEX: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            state_next = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_BEQEX: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b01;
            pc_src     = 2'b01;
            branch     = 1'b1;
            instr_done = 1'b1;
         end
`ifdef MIPS_BNE_EN
         S_BNEEX: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b01;
            pc_src     = 2'b01;
            branch     = 1'b1;
            branch_ne  = 1'b1;
            instr_done = 1'b1;
         end
`endif
         S_JEX: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase

      // branch_ne flips the taken sense so bne reuses the beq datapath
      pc_en = pc_write | (branch & (zero ^ branch_ne));

      if (!rst_n) begin
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         pc_en      = 1'b0;
         pc_src     = 2'b00;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'b00;
         iord       = 1'b0;
         reg_write  = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         alu_op     = 2'b00;
         instr_done = 1'b0;
         illegal_op = 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_main_control.sv
// Self-checking bench for mips_main_control: directed vector table, reset corner cases
// and randomized instructions checked against an instruction-level model.
module tb_mips_main_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic       zero;
   logic       mem_write, ir_write, pc_en, alu_src_a, iord, reg_write, reg_dst, mem_to_reg;
   logic       instr_done, illegal_op;
   logic [1:0] pc_src, alu_src_b, alu_op;
   logic [3:0] state;

   mips_main_control dut (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
      .mem_write(mem_write), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .iord(iord), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_op(alu_op), .state(state),
      .instr_done(instr_done), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       mem_write, ir_write, pc_en;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       iord, reg_write, reg_dst, mem_to_reg;
      logic [1:0] alu_op;
      logic       instr_done, illegal_op;
   } ctl_t;

   ctl_t got;
   always_comb got = {mem_write, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, iord,
                      reg_write, reg_dst, mem_to_reg, alu_op, instr_done, illegal_op};

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic bit bne_enabled();
`ifdef MIPS_BNE_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // Instruction-level model: the state codes an opcode walks through.
   function automatic void build_seq(input logic [5:0] o, output logic [3:0] seq[$]);
      seq = {4'd0, 4'd1};
      case (o)
         6'b100011: seq = {seq, 4'd2, 4'd3, 4'd4};
         6'b101011: seq = {seq, 4'd2, 4'd5};
         6'b000000: seq = {seq, 4'd6, 4'd7};
         6'b001000: seq = {seq, 4'd9, 4'd10};
         6'b000100: seq.push_back(4'd8);
         6'b000010: seq.push_back(4'd11);
         6'b000101: if (bne_enabled()) seq.push_back(4'd12);
         default: ;
      endcase
   endfunction

   // Control values each state must present, straight from the state/output table.
   function automatic ctl_t ctl_for(input logic [3:0] st, input logic z, input bit ill);
      ctl_t c = '0;
      case (st)
         4'd0:  begin c.alu_src_b = 2'b01; c.ir_write = 1; c.pc_en = 1; end
         4'd1:  begin c.alu_src_b = 2'b11; c.illegal_op = ill; c.instr_done = ill; end
         4'd2, 4'd9: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
         4'd3:  c.iord = 1;
         4'd4:  begin c.mem_to_reg = 1; c.reg_write = 1; c.instr_done = 1; end
         4'd5:  begin c.iord = 1; c.mem_write = 1; c.instr_done = 1; end
         4'd6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
         4'd7:  begin c.reg_dst = 1; c.reg_write = 1; c.instr_done = 1; end
         4'd10: begin c.reg_write = 1; c.instr_done = 1; end
         4'd8, 4'd12: begin
            c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.instr_done = 1;
            c.pc_en = (st == 4'd8) ? z : ~z;
         end
         4'd11: begin c.pc_src = 2'b10; c.pc_en = 1; c.instr_done = 1; end
         default: ;
      endcase
      return c;
   endfunction

   // Starts just after a rising edge with the DUT in FETCH; ends the same way.
   task automatic run_instr(input logic [5:0] o, input logic z, input bit scramble,
                            output int lat, output logic done_pc_en);
      logic [3:0] seq[$];
      bit         ill;
      build_seq(o, seq);
      ill = (seq.size() == 2);
      lat = 0;
      done_pc_en = 1'bx;
      op = o;
      zero = z;
      for (int i = 0; i < seq.size(); i++) begin
         @(negedge clk);
         chk($sformatf("state[%0d] op=%b", i, o), {28'd0, state}, {28'd0, seq[i]});
         chk($sformatf("ctl[%0d] op=%b", i, o), {16'd0, got}, {16'd0, ctl_for(seq[i], z, ill)});
         if (instr_done && lat == 0) begin
            lat = i + 1;
            done_pc_en = pc_en;
         end
         @(posedge clk);
         #1;
         if (scramble && i + 1 < seq.size()) begin
            op   = (seq[i+1] == 4'd1 || seq[i+1] == 4'd2) ? o : 6'($urandom);
            zero = (seq[i+1] == 4'd8 || seq[i+1] == 4'd12) ? z : 1'($urandom);
         end
      end
      $display("instr op=%b zero=%b states=%0d lat=%0d", o, z, seq.size(), lat);
   endtask

   typedef struct {
      logic [5:0] op;
      logic       zero;
      int         lat;
      logic       pc_en_done;
   } vec_t;

   vec_t       vecs[$];
   int         lat;
   logic       pe;
   logic [5:0] rop;
   logic [5:0] pool[7];

   initial begin
      vecs.push_back('{6'b100011, 1'b0, 5, 1'b0});
      vecs.push_back('{6'b101011, 1'b1, 4, 1'b0});
      vecs.push_back('{6'b000000, 1'b0, 4, 1'b0});
      vecs.push_back('{6'b001000, 1'b1, 4, 1'b0});
      vecs.push_back('{6'b000100, 1'b1, 3, 1'b1});
      vecs.push_back('{6'b000100, 1'b0, 3, 1'b0});
      vecs.push_back('{6'b000010, 1'b0, 3, 1'b1});
      vecs.push_back('{6'b111111, 1'b0, 2, 1'b0});
`ifdef MIPS_BNE_EN
      vecs.push_back('{6'b000101, 1'b0, 3, 1'b1});
      vecs.push_back('{6'b000101, 1'b1, 3, 1'b0});
`else
      vecs.push_back('{6'b000101, 1'b0, 2, 1'b0});
`endif
      pool = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010, 6'b000101};

      rst_n = 1'b1;
      op    = 6'b100011;
      zero  = 1'b0;
      #2 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_state", {28'd0, state}, 32'd0);
         chk("reset_ctl", {16'd0, got}, 32'd0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (vecs[k]) begin
         run_instr(vecs[k].op, vecs[k].zero, 1'b0, lat, pe);
         chk($sformatf("latency op=%b", vecs[k].op), lat, vecs[k].lat);
         chk($sformatf("done_pc_en op=%b", vecs[k].op), {31'd0, pe}, {31'd0, vecs[k].pc_en_done});
      end

      // Reset while a load sits in MEMRD must abandon it at once.
      op = 6'b100011;
      zero = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_walk", {28'd0, state}, i);
         if (i < 3) begin
            @(posedge clk);
            #1;
         end
      end
      rst_n = 1'b0;
      #1;
      chk("abort_state", {28'd0, state}, 32'd0);
      chk("abort_ctl", {16'd0, got}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_instr(6'b101011, 1'b0, 1'b0, lat, pe);
      chk("after_abort_latency", lat, 4);

      for (int n = 0; n < 40; n++) begin
         rop = ($urandom_range(0, 3) == 0) ? 6'($urandom) : pool[$urandom_range(0, 6)];
         run_instr(rop, 1'($urandom), 1'b1, lat, pe);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mips_main_control.md
Name: mips_main_control

Overview:
- Multi-cycle MIPS main control FSM; the initiator side of the ALUop interface that feeds the ALU function decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath enables and mux selects, plus the 2-bit ALUop.
- Sits beside the ALU decoder in the controller; the datapath returns the opcode and the ALU zero flag.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch if equal
- OP_ADDI, 6'b001000, add immediate
- OP_J, 6'b000010, jump

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low
- op  in  6  opcode field of the instruction register
- zero  in  1  ALU zero flag
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register load
- pc_en  out  1  PC load; equals pc_write OR (branch AND taken-condition)
- pc_src  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- alu_src_a  out  1  0 PC, 1 register A
- alu_src_b  out  2  00 register B, 01 constant 4, 10 sign-extended imm, 11 imm<<2
- iord  out  1  0 PC address, 1 ALUOut address
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 data register
- alu_op  out  2  00 add, 01 sub, 10 use funct
- state  out  4  current state code (debug)
- instr_done  out  1  high in the last cycle of each instruction
- illegal_op  out  1  high in the DECODE cycle for an unsupported opcode

Behaviour:
- State register updates on posedge clk; cleared asynchronously to FETCH when rst_n=0.
- While rst_n=0, all outputs except state are forced to 0, including pc_en and ir_write. The first rising edge after release executes FETCH.
- Reset asserted mid-instruction aborts it immediately. Pending writes are not completed.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BNEEX 12. Codes 13-15 are illegal: go to FETCH, all outputs 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: lw/sw -> MEMADR; R -> RTYPEEX; beq -> BEQEX; addi -> ADDIEX; j -> JEX; other opcodes -> FETCH with illegal_op=1.
  - MEMADR: lw -> MEMRD; sw -> MEMWR.
  - MEMRD -> MEMWB.
  - RTYPEEX -> RTYPEWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, BNEEX, JEX -> FETCH.
- Outputs are Moore, decoded from state. Exception: pc_en also depends combinationally on zero. Any signal not listed for a state is 0.
  - FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=1, pc_write=1.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - MEMADR, ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD: iord=1.
  - MEMWR: iord=1, mem_write=1.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
  - RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10.
  - RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
  - BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1; pc_en=zero.
  - JEX: pc_src=10, pc_write=1.
- alu_op is never 11.
- instr_done is high in the terminal states and in the illegal-opcode DECODE cycle.
- Instruction latencies in cycles: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
- op is sampled only in DECODE and MEMADR. op changing in other states has no effect.

Optional Feature:
- Macro MIPS_BNE_EN.
- When defined: opcode 6'b000101 in DECODE -> BNEEX. BNEEX outputs match BEQEX, except pc_en = NOT zero. Latency 3; instr_done=1 in BNEEX.
- When undefined: opcode 000101 is illegal (illegal_op=1, return to FETCH); state code 12 is unreachable and treated as an illegal code.

Test Plan:
- rst_n=0 for 3 cycles with op=OP_LW, then release -> all outputs 0 during reset; state=0. First cycle after release: ir_write=1, pc_en=1, alu_src_b=01.
- op=100011 (lw) -> state sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4; instr_done pulses once.
- op=000000 (R-type) -> states 0,1,6,7,0. alu_op=10 in state 6; reg_dst=1 with reg_write=1 in state 7.
- op=000100, zero=1, then repeat with zero=0 -> states 0,1,8,0. pc_en=1 in state 8 for the first run, 0 for the second; alu_op=01.
- op=111111 -> states 0,1,0. illegal_op=1 and instr_done=1 in state 1; no write enables asserted.
- With MIPS_BNE_EN: op=000101, zero=0 -> state 12 with pc_en=1. Without MIPS_BNE_EN: op=000101 -> illegal_op=1.
